// File: rtl/sub_64_pipe_pkg.sv
// sub_64_pipe_pkg: shared sizing defaults and status-flag bit positions for the pipelined subtractor.
package sub_64_pipe_pkg;
    localparam int WIDTH_DEF  = 64;
    localparam int STAGES_DEF = 4;
    localparam int SLICE_W    = WIDTH_DEF / STAGES_DEF;
    // Layout of the packed {neg, zero, ovf, bout} status vector used by the ALU status register
    localparam int FLAG_BOUT  = 0;
    localparam int FLAG_OVF   = 1;
    localparam int FLAG_ZERO  = 2;
    localparam int FLAG_NEG   = 3;
endpackage

// File: rtl/sub_64_pipe_slice.sv
// sub_slice: S-bit adder slice; the caller passes the inverted subtrahend so this computes a + ~b + cin.
module sub_slice
    import sub_64_pipe_pkg::*;
#(
    parameter int S = SLICE_W
) (
    input  logic [S-1:0] a_slice,
    input  logic [S-1:0] nb_slice,
    input  logic         cin,
    output logic [S-1:0] s_slice,
    output logic         cout
);
    assign {cout, s_slice} = {1'b0, a_slice} + {1'b0, nb_slice} + {{S{1'b0}}, cin};
endmodule

// File: rtl/sub_64_pipe.sv
// sub_64_pipe: pipelined a - b - bin over STAGES slices with valid/ready on both ends and status flags.
module sub_64_pipe
    import sub_64_pipe_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int STAGES = STAGES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);
    localparam int S = WIDTH / STAGES;
    localparam int L = STAGES - 1;

    logic [STAGES-1:0] valid_q, bw_q, am_q, bm_q;
    logic [STAGES-1:0] bw_d, am_d, bm_d, src_v, sc, sco;
    logic [STAGES:0]   ld;
    logic [WIDTH-1:0]  diff_q [STAGES];
    logic [WIDTH-1:0]  diff_d [STAGES];
    logic [WIDTH-1:0]  a_q [L];
    logic [WIDTH-1:0]  b_q [L];
    logic [WIDTH-1:0]  a_d [L];
    logic [WIDTH-1:0]  b_d [L];
    logic [S-1:0]      sa [STAGES];
    logic [S-1:0]      snb [STAGES];
    logic [S-1:0]      ss [STAGES];
    logic [3:0]        st;

    assign src_v = {valid_q[L-1:0], in_valid};

    // A stage may load when empty or when its successor takes its contents this cycle
    always_comb begin
        ld[STAGES] = out_ready;
        for (int k = L; k >= 0; k--) ld[k] = ~valid_q[k] | ld[k+1];
    end

    genvar i;
    generate
        for (i = 0; i < STAGES; i++) begin : g_st
            if (i == 0) begin : g_first
                assign sa[i]     = a[S-1:0];
                assign snb[i]    = ~b[S-1:0];
                assign sc[i]     = ~bin;
                assign diff_d[i] = WIDTH'(ss[i]);
                assign am_d[i]   = a[WIDTH-1];
                assign bm_d[i]   = b[WIDTH-1];
                assign a_d[i]    = a;
                assign b_d[i]    = b;
            end else begin : g_rest
                assign sa[i]     = a_q[i-1][i*S +: S];
                assign snb[i]    = ~b_q[i-1][i*S +: S];
                assign sc[i]     = ~bw_q[i-1];
                assign diff_d[i] = diff_q[i-1] | (WIDTH'(ss[i]) << (i*S));
                assign am_d[i]   = am_q[i-1];
                assign bm_d[i]   = bm_q[i-1];
                if (i < L) begin : g_pass
                    assign a_d[i] = a_q[i-1];
                    assign b_d[i] = b_q[i-1];
                end
            end
            // Borrows rather than carries are stored so the cleared state reads as bout=0
            assign bw_d[i] = ~sco[i];
            sub_slice #(.S(S)) u_slice (
                .a_slice (sa[i]),
                .nb_slice(snb[i]),
                .cin     (sc[i]),
                .s_slice (ss[i]),
                .cout    (sco[i])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            bw_q    <= '0;
            am_q    <= '0;
            bm_q    <= '0;
            for (int k = 0; k < STAGES; k++) diff_q[k] <= '0;
            for (int k = 0; k < L; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ld[k]) valid_q[k] <= src_v[k];
                if (ld[k] && src_v[k]) begin
                    diff_q[k] <= diff_d[k];
                    bw_q[k]   <= bw_d[k];
                    am_q[k]   <= am_d[k];
                    bm_q[k]   <= bm_d[k];
                end
            end
            for (int k = 0; k < L; k++) begin
                if (ld[k] && src_v[k]) begin
                    a_q[k] <= a_d[k];
                    b_q[k] <= b_d[k];
                end
            end
        end
    end

    assign st[FLAG_BOUT] = bw_q[L];
    assign st[FLAG_OVF]  = (am_q[L] ^ bm_q[L]) & (am_q[L] ^ diff_q[L][WIDTH-1]);
    assign st[FLAG_ZERO] = diff_q[L] == '0;
    assign st[FLAG_NEG]  = diff_q[L][WIDTH-1];

    assign in_ready  = ld[0];
    assign out_valid = valid_q[L];
    assign diff      = diff_q[L];
    assign bout      = st[FLAG_BOUT];
    assign ovf       = st[FLAG_OVF];
    assign zero      = st[FLAG_ZERO];
    assign neg       = st[FLAG_NEG];
endmodule

// File: tb/tb_sub_64_pipe.sv
// tb_sub_64_pipe: directed and random stimulus against an arithmetic reference model with an in-order scoreboard.
module tb_sub_64_pipe;
    logic        clk = 0, reset = 0, in_valid = 0, bin = 0, out_ready = 1;
    logic [63:0] a = '0, b = '0;
    logic        in_ready, out_valid, bout, ovf, zero, neg;
    logic [63:0] diff;

    typedef struct {
        logic [63:0] d;
        logic        bo, ov, z, n;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0, n_err = 0, n_acc = 0, n_out = 0;

    sub_64_pipe dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .bin      (bin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .diff     (diff),
        .bout     (bout),
        .ovf      (ovf),
        .zero     (zero),
        .neg      (neg)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [63:0] x, input logic [63:0] y, input logic c);
        exp_t        e;
        logic [65:0] s;
        e.d  = x - y - 64'(c);
        s    = {{2{x[63]}}, x} - {{2{y[63]}}, y} - 66'(c);
        e.bo = ({1'b0, y} + 65'(c)) > {1'b0, x};
        e.ov = s != {{2{e.d[63]}}, e.d};
        e.z  = e.d == 64'd0;
        e.n  = e.d[63];
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic rnd_ops();
        a   = {$urandom(), $urandom()};
        b   = {$urandom(), $urandom()};
        bin = 1'($urandom_range(0, 1));
    endtask

    task automatic tick();
        exp_t e;
        #1;
        if (out_valid && out_ready) begin
            chk("model_has_entry", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("sb_diff", diff, e.d);
                chk("sb_bout", 64'(bout), 64'(e.bo));
                chk("sb_ovf", 64'(ovf), 64'(e.ov));
                chk("sb_zero", 64'(zero), 64'(e.z));
                chk("sb_neg", 64'(neg), 64'(e.n));
                n_out++;
            end
        end
        if (in_valid && in_ready) begin
            q.push_back(model(a, b, bin));
            n_acc++;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic single(input logic [63:0] x, input logic [63:0] y, input logic c,
                          input logic [63:0] ed, input logic ebo, input logic eov,
                          input logic ez, input logic en);
        a = x;
        b = y;
        bin = c;
        in_valid = 1;
        tick();
        in_valid = 0;
        rnd_ops();
        for (int i = 1; i <= 3; i++) begin
            chk("latency_early", 64'(out_valid), 64'd0);
            tick();
        end
        chk("latency_valid", 64'(out_valid), 64'd1);
        chk("dir_diff", diff, ed);
        chk("dir_bout", 64'(bout), 64'(ebo));
        chk("dir_ovf", 64'(ovf), 64'(eov));
        chk("dir_zero", 64'(zero), 64'(ez));
        chk("dir_neg", 64'(neg), 64'(en));
        tick();
    endtask

    initial begin
        int          acc0, out0;
        logic [63:0] held;
        #1 reset = 1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_diff", diff, 64'd0);
        chk("rst_bout", 64'(bout), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_zero", 64'(zero), 64'd1);
        chk("rst_neg", 64'(neg), 64'd0);
        @(negedge clk);
        reset = 0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        single(64'd10, 64'd3, 1'b0, 64'd7, 0, 0, 0, 0);
        single(64'd0, 64'd1, 1'b0, '1, 1, 0, 0, 1);
        single(64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 0, 1, 0, 0);
        single(64'h1234, 64'h1234, 1'b1, '1, 1, 0, 0, 1);
        single(64'h0000_0001_0000_0000, 64'd1, 1'b0, 64'h0000_0000_FFFF_FFFF, 0, 0, 0, 0);
        single(64'd5, 64'd5, 1'b0, 64'd0, 0, 0, 1, 0);

        // Back-pressure: fill with out_ready low, operands churn every cycle
        out_ready = 0;
        acc0 = n_acc;
        out0 = n_out;
        held = '0;
        for (int t = 0; t < 10; t++) begin
            in_valid = 1;
            rnd_ops();
            #1;
            chk("bp_in_ready", 64'(in_ready), 64'(t < 4));
            chk("bp_out_valid", 64'(out_valid), 64'(t >= 4));
            if (t == 4) held = diff;
            if (t >= 4) begin
                chk("bp_front", diff, q[0].d);
                chk("bp_stable", diff, held);
            end
            tick();
        end
        chk("bp_accepts", 64'(n_acc - acc0), 64'd4);
        out_ready = 1;
        for (int t = 0; t < 40 && (n_acc - acc0) < 8; t++) begin
            in_valid = 1;
            rnd_ops();
            tick();
        end
        in_valid = 0;
        for (int t = 0; t < 20 && q.size() != 0; t++) tick();
        chk("bp_outputs", 64'(n_out - out0), 64'd8);
        chk("bp_drained", 64'(q.size()), 64'd0);
        chk("bp_no_dup", 64'(out_valid), 64'd0);

        for (int t = 0; t < 150; t++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            rnd_ops();
            tick();
        end
        in_valid  = 0;
        out_ready = 1;
        for (int t = 0; t < 20 && q.size() != 0; t++) tick();
        chk("rand_drained", 64'(q.size()), 64'd0);

        // Reset with three results in flight
        for (int t = 0; t < 3; t++) begin
            in_valid = 1;
            rnd_ops();
            tick();
        end
        in_valid = 0;
        #1 reset = 1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_diff", diff, 64'd0);
        chk("midrst_zero", 64'(zero), 64'd1);
        chk("midrst_bout", 64'(bout), 64'd0);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        #1;
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        for (int t = 0; t < 6; t++) begin
            tick();
            chk("midrst_no_stale", 64'(out_valid), 64'd0);
        end
        single(64'd9, 64'd4, 1'b0, 64'd5, 0, 0, 0, 0);
        chk("final_drained", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
